// File: rtl/guffin_vend_ctrl.sv
// Guffin vending controller: quarter/half-dollar credit, one-cycle dispense, handshaked change payout.
// Optional refund-on-cancel is built only when GUFFIN_CANCEL_EN is defined.
module guffin_vend_ctrl #(
  parameter int PRICE_Q  = 3,
  parameter int CREDIT_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_q,
  input  logic                coin_h,
  input  logic                cancel,
  input  logic                chg_ack,
  output logic                guffin,
  output logic                chg_valid,
  output logic                chg_half,
  output logic                chg_quarter,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (PRICE_Q < 1 || PRICE_Q > (1 << CREDIT_W) - 3) begin : g_bad_price
    $error("guffin_vend_ctrl: PRICE_Q out of range for CREDIT_W");
  end

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_Q);
  localparam logic [CREDIT_W-1:0] TWO   = CREDIT_W'(2);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] coin_val;
  logic                any_coin;
  logic                reject_d;
  logic                take_cancel;
  logic                guffin_q, chg_valid_q, chg_half_q, chg_quarter_q, coin_reject_q, busy_q;

  assign coin_val = CREDIT_W'({coin_h, coin_q});
  assign any_coin = coin_q | coin_h;

`ifdef GUFFIN_CANCEL_EN
  assign take_cancel = cancel && (credit_q != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign take_cancel   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    case (state_q)
      COLLECT: begin
        // A refund request beats a simultaneous coin, which is handed back.
        if (take_cancel) begin
          state_d  = CHANGE;
          reject_d = any_coin;
        end else if (any_coin) begin
          credit_d = credit_q + coin_val;
          if (credit_d >= PRICE) state_d = VEND;
        end
      end
      VEND: begin
        reject_d = any_coin;
        credit_d = credit_q - PRICE;
        state_d  = (credit_d != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        reject_d = any_coin;
        if (chg_ack) begin
          credit_d = credit_q - ((credit_q >= TWO) ? TWO : CREDIT_W'(1));
          if (credit_d == '0) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q/credit_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= COLLECT;
      credit_q      <= '0;
      guffin_q      <= 1'b0;
      chg_valid_q   <= 1'b0;
      chg_half_q    <= 1'b0;
      chg_quarter_q <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      guffin_q      <= (state_d == VEND);
      chg_valid_q   <= (state_d == CHANGE);
      chg_half_q    <= (state_d == CHANGE) && (credit_d >= TWO);
      chg_quarter_q <= (state_d == CHANGE) && (credit_d < TWO);
      coin_reject_q <= reject_d;
      busy_q        <= (state_d != COLLECT);
    end
  end

  assign guffin      = guffin_q;
  assign chg_valid   = chg_valid_q;
  assign chg_half    = chg_half_q;
  assign chg_quarter = chg_quarter_q;
  assign coin_reject = coin_reject_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_guffin_vend_ctrl.sv
// Scoreboard bench for guffin_vend_ctrl: a coin-level model queues expected dispenses,
// change coins and rejects; a negedge monitor pops and compares them as the DUT presents them.
module tb_guffin_vend_ctrl;

  localparam int PRICE_Q  = 3;
  localparam int CREDIT_W = 3;
`ifdef GUFFIN_CANCEL_EN
  localparam bit CANCEL_EN = 1'b1;
`else
  localparam bit CANCEL_EN = 1'b0;
`endif

  logic                clk, reset_n;
  logic                coin_q, coin_h, cancel, chg_ack;
  logic                guffin, chg_valid, chg_half, chg_quarter, coin_reject, busy;
  logic [CREDIT_W-1:0] credit;

  guffin_vend_ctrl #(.PRICE_Q(PRICE_Q), .CREDIT_W(CREDIT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .coin_q(coin_q), .coin_h(coin_h), .cancel(cancel), .chg_ack(chg_ack),
    .guffin(guffin), .chg_valid(chg_valid), .chg_half(chg_half), .chg_quarter(chg_quarter),
    .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int credit_m = 0;
  bit ack_en = 1'b0;

  int q_vend[$];   // credit shown while the guffin pulse is out
  bit q_chg[$];    // 1 = half-dollar, 0 = quarter, in payout order
  bit q_rej[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Change is paid largest coin first.
  task automatic push_change(input int amount);
    int n;
    n = amount;
    while (n > 0) begin
      if (n >= 2) begin q_chg.push_back(1'b1); n -= 2; end
      else begin q_chg.push_back(1'b0); n -= 1; end
    end
  endtask

  task automatic step(input logic q, input logic h, input logic c);
    @(posedge clk); #1;
    coin_q = q; coin_h = h; cancel = c;
  endtask

  // One customer action; optionally follow with a coin that must be refused while busy.
  task automatic txn(input logic q, input logic h, input logic c, input logic rq, input logic rh);
    int v;
    bit went;
    v = int'(q) + 2 * int'(h);
    went = 1'b0;
    if (CANCEL_EN && c && credit_m > 0) begin
      if (v > 0) q_rej.push_back(1'b1);
      push_change(credit_m);
      credit_m = 0;
      went = 1'b1;
    end else if (v > 0) begin
      credit_m += v;
      if (credit_m >= PRICE_Q) begin
        q_vend.push_back(credit_m);
        push_change(credit_m - PRICE_Q);
        credit_m = 0;
        went = 1'b1;
      end
    end
    step(q, h, c);
    if (went && (rq || rh)) begin
      q_rej.push_back(1'b1);
      step(rq, rh, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
    end
    check("idle_reached", busy, 0);
    check("idle_credit", credit, credit_m);
  endtask

  initial begin
    chg_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      chg_ack = ack_en ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (guffin) begin
        check("guffin_expected", int'(q_vend.size() > 0), 1);
        if (q_vend.size() > 0) check("guffin_credit", credit, q_vend.pop_front());
      end
      if (chg_valid) begin
        check("chg_expected", int'(q_chg.size() > 0), 1);
        if (q_chg.size() > 0) begin
          int sum;
          sum = 0;
          foreach (q_chg[i]) sum += q_chg[i] ? 2 : 1;
          check("chg_half", chg_half, q_chg[0]);
          check("chg_quarter", chg_quarter, !q_chg[0]);
          check("chg_credit", credit, sum);
          if (chg_ack) void'(q_chg.pop_front());
        end
      end else begin
        check("chg_type_idle", int'({chg_half, chg_quarter}), 0);
      end
      if (coin_reject) begin
        check("reject_expected", int'(q_rej.size() > 0), 1);
        if (q_rej.size() > 0) void'(q_rej.pop_front());
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0;
    coin_q = 1'b0; coin_h = 1'b0; cancel = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      coin_q = 1'b1; coin_h = i[0]; cancel = i[1];
      @(negedge clk);
      check("rst_outputs", int'({guffin, chg_valid, chg_half, chg_quarter, coin_reject, busy}), 0);
      check("rst_credit", credit, 0);
    end
    @(posedge clk); #1;
    coin_q = 1'b0; coin_h = 1'b0; cancel = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_outputs", int'({guffin, chg_valid, chg_half, chg_quarter, coin_reject, busy}), 0);
    check("post_rst_credit", credit, 0);
    ack_en = 1'b1;

    // Three quarters: exact price, busy for one cycle, no change.
    txn(1, 0, 0, 0, 0); wait_idle(n);
    txn(1, 0, 0, 0, 0); wait_idle(n);
    txn(1, 0, 0, 0, 0); wait_idle(n);
    check("exact_busy_cycles", n, 1);

    // Two half-dollars: one quarter of change.
    txn(0, 1, 0, 0, 0); wait_idle(n);
    txn(0, 1, 0, 0, 0); wait_idle(n);

    // Credit 2 then both coins together, with a stalled ack and refused coins.
    txn(0, 1, 0, 0, 0); wait_idle(n);
    ack_en = 1'b0;
    txn(1, 1, 0, 0, 1);
    repeat (3) @(negedge clk);
    q_rej.push_back(1'b1);
    step(0, 1, 0);
    step(0, 0, 0);
    repeat (3) @(negedge clk);
    ack_en = 1'b1;
    wait_idle(n);

    // Reset pulled in the middle of a change payout forfeits it.
    txn(0, 1, 0, 0, 0); wait_idle(n);
    ack_en = 1'b0;
    txn(0, 1, 0, 0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midchg_rst_outputs", int'({guffin, chg_valid, chg_half, chg_quarter, coin_reject, busy}), 0);
    check("midchg_rst_credit", credit, 0);
    q_chg.delete();
    credit_m = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ack_en = 1'b1;
    wait_idle(n);

    // Cancel with credit 2, then cancel racing a coin.
    txn(0, 1, 0, 0, 0); wait_idle(n);
    txn(0, 0, 1, 0, 0); wait_idle(n);
    txn(1, 0, 0, 0, 0); wait_idle(n);
    txn(1, 0, 1, 0, 0); wait_idle(n);

    for (int t = 0; t < 250; t++) begin
      logic q, h, c, rq, rh;
      q  = 1'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      c  = ($urandom_range(0, 3) == 0);
      rq = ($urandom_range(0, 2) == 0);
      rh = ($urandom_range(0, 2) == 0);
      txn(q, h, c, rq, rh);
      wait_idle(n);
    end

    repeat (10) @(negedge clk);
    check("vend_queue_drained", q_vend.size(), 0);
    check("chg_queue_drained", q_chg.size(), 0);
    check("rej_queue_drained", q_rej.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
